// File: rtl/cnc_pkg.sv
`timescale 1ns/1ps
// cnc_pkg
// Shared definitions for the step/direction pulse generator:
//   - default widths and timing parameters
//   - the pulse generator FSM state type
package cnc_pkg;

    localparam int CNT_WIDTH_DEF   = 32;   // width of step count / period fields
    localparam int PULSE_WIDTH_DEF = 100;  // step high time in clock cycles
    localparam int DIR_SETUP_DEF   = 50;   // direction-to-step setup in cycles

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } step_state_t;

endpackage

// File: rtl/step_timer.sv
`timescale 1ns/1ps
// step_timer
// Phase down-counter. Loaded with (phase length - 1) on entry to a phase,
// it counts down to zero and holds there (no wrap-around). 'expired' is
// high during the last cycle of the phase.
// Ports:
//   ACLK, ARESETN  clock, asynchronous active-low reset
//   load           load load_value on the next rising edge
//   load_value     value to load
//   value          current count
//   expired        count has reached zero
module step_timer #(
    parameter int WIDTH = cnc_pkg::CNT_WIDTH_DEF
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             expired
);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - WIDTH'(1);
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/step_pulse_gen.sv
`timescale 1ns/1ps
// step_pulse_gen
// Turns accepted move commands into step/direction pulses for a motor driver.
// A move optionally waits DIR_SETUP cycles after a direction change, then
// issues cmd_steps pulses of PULSE_WIDTH high cycles, each pulse occupying
// max(cmd_period, 2*PULSE_WIDTH) cycles in total.
// Ports:
//   ACLK, ARESETN    clock, asynchronous active-low reset
//   enable           allows new commands to be accepted
//   cmd_valid/ready  command handshake; transfer when both high on a rising
//                    edge. ready is combinational and never depends on valid.
//   cmd_steps/period/dir  command payload, sampled at the transfer edge
//   abort            level request to stop the current move
//   step_out/dir_out motor driver outputs
//   busy             a move is in progress
//   done             one-cycle pulse when a move ends (normal, aborted, empty)
//   steps_remaining  pulses not yet started
//   fsm_state        current FSM state, for observation
module step_pulse_gen
    import cnc_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int PULSE_WIDTH = PULSE_WIDTH_DEF,
    parameter int DIR_SETUP   = DIR_SETUP_DEF
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 enable,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CNT_WIDTH-1:0] cmd_steps,
    input  logic [CNT_WIDTH-1:0] cmd_period,
    input  logic                 cmd_dir,
    input  logic                 abort,
    output logic                 step_out,
    output logic                 dir_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] steps_remaining,
    output logic [1:0]           fsm_state
);

    // Timer load values are phase length minus one: the timer expires in
    // the last cycle of the phase.
    localparam logic [CNT_WIDTH-1:0] HIGH_LOAD  = CNT_WIDTH'(PULSE_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] SETUP_LOAD = CNT_WIDTH'(DIR_SETUP - 1);
    localparam logic [CNT_WIDTH-1:0] MIN_PERIOD = CNT_WIDTH'(2 * PULSE_WIDTH);

    step_state_t          state, state_next;
    logic                 dir_q, dir_next;
    logic                 done_next;
    logic [CNT_WIDTH-1:0] rem_q, rem_next;
    logic [CNT_WIDTH-1:0] period_q, period_next;
    logic                 abort_seen, abort_seen_next;
    logic                 tmr_load;
    logic [CNT_WIDTH-1:0] tmr_load_value;
    logic [CNT_WIDTH-1:0] low_load;
    logic                 tmr_expired;
    logic [CNT_WIDTH-1:0] tmr_value;
    logic                 accept;

    step_timer #(.WIDTH(CNT_WIDTH)) u_timer (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .value      (tmr_value),
        .expired    (tmr_expired)
    );

    // period_q >= 2*PULSE_WIDTH, so the low phase is always >= PULSE_WIDTH.
    assign low_load = period_q - CNT_WIDTH'(PULSE_WIDTH + 1);

    assign cmd_ready = (state == IDLE) && enable && !abort;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_next     = state;
        dir_next       = dir_q;
        done_next      = 1'b0;
        rem_next       = rem_q;
        period_next    = period_q;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    period_next = (cmd_period > MIN_PERIOD) ? cmd_period : MIN_PERIOD;
                    rem_next    = cmd_steps;
                    if (cmd_steps == '0) begin
                        done_next = 1'b1;
                    end else if (cmd_dir != dir_q) begin
                        dir_next       = cmd_dir;
                        state_next     = SETUP;
                        tmr_load       = 1'b1;
                        tmr_load_value = SETUP_LOAD;
                    end else begin
                        // Entering HIGH counts this pulse as started.
                        rem_next       = cmd_steps - CNT_WIDTH'(1);
                        state_next     = HIGH;
                        tmr_load       = 1'b1;
                        tmr_load_value = HIGH_LOAD;
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    rem_next   = '0;
                end else if (tmr_expired) begin
                    state_next     = HIGH;
                    rem_next       = rem_q - CNT_WIDTH'(1);
                    tmr_load       = 1'b1;
                    tmr_load_value = HIGH_LOAD;
                end
            end
            HIGH: begin
                // An abort seen at any point of the high phase is honoured
                // only once the pulse has its full width.
                if (tmr_expired) begin
                    if (abort || abort_seen) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        rem_next   = '0;
                    end else begin
                        state_next     = LOW;
                        tmr_load       = 1'b1;
                        tmr_load_value = low_load;
                    end
                end
            end
            LOW: begin
                if (abort) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    rem_next   = '0;
                end else if (tmr_expired) begin
                    if (rem_q == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next     = HIGH;
                        rem_next       = rem_q - CNT_WIDTH'(1);
                        tmr_load       = 1'b1;
                        tmr_load_value = HIGH_LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign abort_seen_next = (state == HIGH) && (state_next == HIGH) && (abort || abort_seen);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            dir_q      <= 1'b0;
            done       <= 1'b0;
            rem_q      <= '0;
            period_q   <= '0;
            abort_seen <= 1'b0;
        end else begin
            state      <= state_next;
            dir_q      <= dir_next;
            done       <= done_next;
            rem_q      <= rem_next;
            period_q   <= period_next;
            abort_seen <= abort_seen_next;
        end
    end

    // step_out decodes the state register directly, so reset drops it at once.
    assign step_out        = (state == HIGH);
    assign busy            = (state != IDLE);
    assign dir_out         = dir_q;
    assign steps_remaining = rem_q;
    assign fsm_state       = state;

endmodule

// File: tb/tb_step_pulse_gen.sv
`timescale 1ns/1ps
// tb_step_pulse_gen
// Self-checking bench: each move is expanded by a cycle-level reference
// model into the expected per-cycle outputs {steps_remaining, dir_out,
// done, busy, step_out}, queued in exp_q and compared on falling edges.
module tb_step_pulse_gen;

    localparam int CW = 16;
    localparam int PW = 4;
    localparam int DS = 3;
    localparam int EW = CW + 4;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic          enable;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_steps;
    logic [CW-1:0] cmd_period;
    logic          cmd_dir;
    logic          abort;
    logic          step_out;
    logic          dir_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] steps_remaining;
    logic [1:0]    fsm_state;

    int checks = 0;
    int passed = 0;
    logic          dir_model;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs;

    assign obs = {steps_remaining, dir_out, done, busy, step_out};

    step_pulse_gen #(.CNT_WIDTH(CW), .PULSE_WIDTH(PW), .DIR_SETUP(DS)) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .enable          (enable),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_steps       (cmd_steps),
        .cmd_period      (cmd_period),
        .cmd_dir         (cmd_dir),
        .abort           (abort),
        .step_out        (step_out),
        .dir_out         (dir_out),
        .busy            (busy),
        .done            (done),
        .steps_remaining (steps_remaining),
        .fsm_state       (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] pack(input int rem, input logic d,
                                           input logic dn, input logic bz, input logic st);
        return {CW'(rem), d, dn, bz, st};
    endfunction

    // Expected outputs for the cycles following the accept edge.
    task automatic build_move(input int steps, input int period, input logic dir);
        int eff;
        eff = (period > 2 * PW) ? period : 2 * PW;
        exp_q.delete();
        if (steps == 0) begin
            exp_q.push_back(pack(0, dir_model, 1'b1, 1'b0, 1'b0));
        end else begin
            if (dir != dir_model) begin
                for (int i = 0; i < DS; i++) exp_q.push_back(pack(steps, dir, 1'b0, 1'b1, 1'b0));
            end
            for (int k = 0; k < steps; k++) begin
                for (int i = 0; i < PW; i++)       exp_q.push_back(pack(steps - 1 - k, dir, 1'b0, 1'b1, 1'b1));
                for (int i = 0; i < eff - PW; i++) exp_q.push_back(pack(steps - 1 - k, dir, 1'b0, 1'b1, 1'b0));
            end
            exp_q.push_back(pack(0, dir, 1'b1, 1'b0, 1'b0));
            dir_model = dir;
        end
        exp_q.push_back(pack(0, dir_model, 1'b0, 1'b0, 1'b0));
    endtask

    // ---------------- driver / scoreboard ----------------
    task automatic offer_cmd(input string name, input int steps, input int period, input logic dir);
        @(negedge ACLK);
        cmd_steps  = CW'(steps);
        cmd_period = CW'(period);
        cmd_dir    = dir;
        cmd_valid  = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1)
            $display("FAIL %s ready: got %b expected 1", name, cmd_ready);
        else
            passed++;
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        logic [EW-1:0] exp;
        int j;
        j = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            @(negedge ACLK);
            checks++;
            if (obs !== exp)
                $display("FAIL %s cycle %0d {rem,dir,done,busy,step}: got %h expected %h", name, j, obs, exp);
            else
                passed++;
            j++;
        end
    endtask

    task automatic run_move(input string name, input int steps, input int period,
                            input logic dir, input logic drop_en);
        build_move(steps, period, dir);
        offer_cmd(name, steps, period, dir);
        if (drop_en) enable = 1'b0;  // must not disturb the running move
        drain(name);
        enable = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ARESETN    = 1'b0;
        enable     = 1'b1;
        cmd_valid  = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        cmd_dir    = 1'b0;
        abort      = 1'b0;
        dir_model  = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if ({obs, fsm_state} !== '0)
            $display("FAIL reset_outputs: got %h expected 0", {obs, fsm_state});
        else
            passed++;
        @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic test_enable_gate();
        @(negedge ACLK);
        enable     = 1'b0;
        cmd_steps  = CW'(2);
        cmd_period = CW'(10);
        cmd_valid  = 1'b1;
        repeat (3) begin
            @(negedge ACLK);
            checks++;
            if ({cmd_ready, busy} !== 2'b00)
                $display("FAIL enable_gate {ready,busy}: got %b expected 00", {cmd_ready, busy});
            else
                passed++;
        end
        cmd_valid = 1'b0;
        enable    = 1'b1;
    endtask

    task automatic test_directed();
        run_move("same_dir_3x10", 3, 10, 1'b0, 1'b0);
        run_move("dir_change_1x8", 1, 8, 1'b1, 1'b0);
        run_move("zero_steps", 0, 5, 1'b0, 1'b0);
        run_move("clamped_period", 2, 2, 1'b1, 1'b0);
        run_move("enable_dropped", 2, 9, 1'b1, 1'b1);
    endtask

    // Abort raised in the second high cycle of the first pulse.
    task automatic test_abort_high();
        logic [EW-1:0] exp;
        logic d;
        d = dir_model;
        exp_q.delete();
        for (int i = 0; i < PW; i++) exp_q.push_back(pack(4, d, 1'b0, 1'b1, 1'b1));
        exp_q.push_back(pack(0, d, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(pack(0, d, 1'b0, 1'b0, 1'b0));
        offer_cmd("abort_high", 5, 10, d);
        for (int j = 0; j < PW + 2; j++) begin
            exp = exp_q.pop_front();
            @(negedge ACLK);
            checks++;
            if (obs !== exp)
                $display("FAIL abort_high cycle %0d: got %h expected %h", j, obs, exp);
            else
                passed++;
            if (j == 1) abort = 1'b1;
            if (j == PW) begin
                checks++;
                if (cmd_ready !== 1'b0)
                    $display("FAIL abort_blocks_ready: got %b expected 0", cmd_ready);
                else
                    passed++;
                abort = 1'b0;
            end
        end
    endtask

    // Abort raised in the second low cycle of the first pulse.
    task automatic test_abort_low();
        logic [EW-1:0] exp;
        logic d;
        d = dir_model;
        exp_q.delete();
        for (int i = 0; i < PW; i++) exp_q.push_back(pack(2, d, 1'b0, 1'b1, 1'b1));
        for (int i = 0; i < 2; i++)  exp_q.push_back(pack(2, d, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(pack(0, d, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(pack(0, d, 1'b0, 1'b0, 1'b0));
        offer_cmd("abort_low", 3, 10, d);
        for (int j = 0; j < PW + 4; j++) begin
            exp = exp_q.pop_front();
            @(negedge ACLK);
            checks++;
            if (obs !== exp)
                $display("FAIL abort_low cycle %0d: got %h expected %h", j, obs, exp);
            else
                passed++;
            if (j == PW + 1) abort = 1'b1;
            if (j == PW + 2) abort = 1'b0;
        end
    endtask

    task automatic test_reset_mid_move();
        logic d;
        d = dir_model;
        offer_cmd("reset_mid", 3, 10, d);
        @(negedge ACLK);
        @(negedge ACLK);
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if ({obs, fsm_state} !== '0)
            $display("FAIL reset_mid_truncate: got %h expected 0", {obs, fsm_state});
        else
            passed++;
        dir_model  = 1'b0;
        cmd_steps  = CW'(2);
        cmd_period = CW'(8);
        cmd_dir    = 1'b0;
        cmd_valid  = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        checks++;
        if (obs !== '0)
            $display("FAIL reset_mid_no_done: got %h expected 0", obs);
        else
            passed++;
        build_move(2, 8, 1'b0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
        drain("reset_then_accept");
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int s, p;
            logic d, de;
            s  = $urandom_range(0, 4);
            p  = $urandom_range(0, 14);
            d  = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            run_move($sformatf("random_%0d", n), s, p, d, de);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_enable_gate();
        test_directed();
        test_abort_high();
        test_abort_low();
        test_reset_mid_move();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 32, meaning the width of step count and period fields.
REQ-002 The block SHALL have parameter PULSE_WIDTH, default 100, meaning the step high time in ACLK cycles (>=1).
REQ-003 The block SHALL have parameter DIR_SETUP, default 50, meaning the direction-to-step setup time in ACLK cycles (>=1).
REQ-004 ACLK  input  1  the single clock; all logic rising-edge.
REQ-005 ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-006 enable  input  1  the AXI-Lite control register enable bit; gates command acceptance.
REQ-007 cmd_valid  input  1  move command offered by the register block.
REQ-008 cmd_ready  output  1  move command accepted when both are high on a rising edge.
REQ-009 cmd_steps  input  CNT_WIDTH  number of step pulses to issue.
REQ-010 cmd_period  input  CNT_WIDTH  step period in cycles.
REQ-011 cmd_dir  input  1  requested direction.
REQ-012 abort  input  1  level request to stop the current move.
REQ-013 step_out  output  1  step pulse to the motor driver.
REQ-014 dir_out  output  1  direction to the motor driver.
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 done  output  1  one-cycle pulse at the end of a move, including aborted and zero-step moves.
REQ-017 steps_remaining  output  CNT_WIDTH  pulses not yet started; read back through the register block.

Function
REQ-018 The FSM SHALL have the states IDLE, SETUP, HIGH and LOW.
REQ-019 cmd_ready SHALL equal (state==IDLE) && enable && !abort, as a combinational output.
REQ-020 On accept with cmd_steps==0, the block SHALL stay in IDLE and pulse done in the next cycle, leaving dir_out unchanged.
REQ-021 On accept with cmd_steps>0 and cmd_dir!=dir_out, the block SHALL load dir_out and enter SETUP for exactly DIR_SETUP cycles, then enter HIGH.
REQ-022 On accept with cmd_steps>0 and cmd_dir==dir_out, the block SHALL enter HIGH directly, so step_out rises in the cycle after the accept edge.
REQ-023 The effective period SHALL be max(cmd_period, 2*PULSE_WIDTH), latched at accept.
REQ-024 The block SHALL hold step_out=1 in HIGH for PULSE_WIDTH cycles, and step_out=0 in LOW for (effective period - PULSE_WIDTH) cycles.
REQ-025 steps_remaining SHALL load cmd_steps at accept and decrement by 1 on each entry to HIGH.
REQ-026 At the end of LOW with steps_remaining==0, the block SHALL pulse done and enter IDLE; otherwise it SHALL re-enter HIGH.
REQ-027 An abort in SETUP or LOW SHALL cause IDLE plus a done pulse on the next edge.
REQ-028 An abort in HIGH SHALL let the high phase complete (no runt pulse), then go to IDLE with a done pulse, skipping LOW.
REQ-029 An abort SHALL clear steps_remaining to 0 when it reaches IDLE.
REQ-030 Deasserting enable mid-move SHALL NOT affect the move in progress; it only blocks new accepts.
REQ-031 The period timer SHALL be a CNT_WIDTH down-counter with no wrap-around; it reloads at each phase entry.

Reset
REQ-032 With ARESETN low, the block SHALL force state=IDLE, step_out=0, dir_out=0, busy=0, done=0, steps_remaining=0 and timer=0 immediately.
REQ-033 Reset mid-move SHALL truncate any pulse, issue no done, and discard the command.
REQ-034 After release, the first accept SHALL be possible on the first rising edge with ARESETN high.

Structure
REQ-035 The state enum, the CNT_WIDTH default and the timing defaults SHALL live in the shared package cnc_pkg.
REQ-036 The phase timer SHALL be the single sub-module step_timer (load, value, expire flag).

Verification
REQ-037 With PULSE_WIDTH=4, DIR_SETUP=3: a same-direction move of steps=3, period=10 SHALL produce 3 pulses, each 4 cycles high and 6 low; done SHALL pulse 30 cycles after accept; steps_remaining SHALL read 2,1,0.
REQ-038 A direction change with steps=1, period=8 SHALL toggle dir_out at accept, and step_out SHALL rise exactly 3 cycles later.
REQ-039 A move with steps=0 SHALL produce no pulse, a done pulse 1 cycle after accept, and busy staying 0.
REQ-040 A move with period=2 (clamped to 8) SHALL give pulses 4 high / 4 low.
REQ-041 An abort asserted in cycle 2 of HIGH with steps=5 SHALL give a pulse of the full 4 cycles, then done and IDLE, with steps_remaining=0.
REQ-042 ARESETN pulsed low mid-HIGH SHALL drop step_out in the same cycle, with no done; cmd_valid held high SHALL then be accepted on the first edge after release.
